// File: rtl/sram_controller.sv
// sram_controller
//
// Memory-side responder for the pipeline's MEM stage. Each 32-bit word
// load or store is served as two 16-bit accesses on an external
// asynchronous SRAM: low half first, then high half. `ready` stays low
// while an access is in flight so the pipeline freeze logic can stall
// until the word is complete.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   rd_en       load request from MEM stage
//   wr_en       store request from MEM stage (wins over rd_en)
//   address     byte address, word aligned (bits [1:0] ignored)
//   write_data  store data
//   read_data   assembled load data for the MEM/WB register
//   ready       1 when idle with no request or when an access completes
//   sram_dq     bidirectional SRAM data bus
//   sram_addr   SRAM half-word address
//   sram_we_n   SRAM write enable, active low
//   sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n  tied low
module sram_controller #(
  parameter logic [31:0] BASE_ADDR     = 32'd1024,
  parameter int          HALF_CYCLES   = 2,
  parameter int          SRAM_ADDR_LEN = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic                     wr_en,
  input  logic [31:0]              address,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data,
  output logic                     ready,
  inout  wire  [15:0]              sram_dq,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic                     sram_we_n,
  output logic                     sram_ub_n,
  output logic                     sram_lb_n,
  output logic                     sram_ce_n,
  output logic                     sram_oe_n
);

  localparam int CNT_W = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t                   state;
  state_t                   next_state;
  logic [CNT_W-1:0]         counter;
  logic [CNT_W-1:0]         next_counter;
  logic                     op_write;
  logic [SRAM_ADDR_LEN-2:0] index;
  logic [31:0]              wdata;
  logic [31:0]              offset;
  logic                     request;
  logic                     last_cycle;
  logic                     drive_bus;

  // The subtraction wraps naturally, which gives the modulo-2^(N-1)
  // word index for out-of-range addresses.
  assign offset     = address - BASE_ADDR;
  assign request    = rd_en | wr_en;
  assign last_cycle = (counter == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= next_state;
      counter <= next_counter;
    end
  end

  always_comb begin
    next_state   = state;
    next_counter = counter;
    ready        = 1'b0;
    case (state)
      IDLE: begin
        ready = ~request;
        if (request) begin
          next_state   = LOW;
          next_counter = '0;
        end
      end
      LOW: begin
        if (last_cycle) begin
          next_state   = HIGH;
          next_counter = '0;
        end else begin
          next_counter = counter + 1'b1;
        end
      end
      HIGH: begin
        if (last_cycle) begin
          next_state   = DONE;
          next_counter = '0;
        end else begin
          next_counter = counter + 1'b1;
        end
      end
      DONE: begin
        ready      = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state   = IDLE;
        next_counter = '0;
      end
    endcase
  end

  // Requests are sampled only in IDLE; anything the MEM stage does while
  // an access is in flight is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_write <= 1'b0;
      index    <= '0;
      wdata    <= '0;
    end else if (state == IDLE && request) begin
      op_write <= wr_en;
      index    <= offset[SRAM_ADDR_LEN:2];
      wdata    <= write_data;
    end
  end

  // sram_addr is registered so it is valid from the first cycle of LOW
  // and simply holds its last value through DONE and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr <= '0;
    end else if (state == IDLE && request) begin
      sram_addr <= {offset[SRAM_ADDR_LEN:2], 1'b0};
    end else if (state == LOW && last_cycle) begin
      sram_addr <= {index, 1'b1};
    end
  end

  // Each half is captured on the final clock of its phase, giving the
  // SRAM the full phase to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data <= '0;
    end else if (!op_write && last_cycle) begin
      if (state == LOW) begin
        read_data[15:0] <= sram_dq;
      end else if (state == HIGH) begin
        read_data[31:16] <= sram_dq;
      end
    end
  end

  assign drive_bus = op_write && (state == LOW || state == HIGH);
  assign sram_we_n = ~drive_bus;
  assign sram_dq   = drive_bus ? ((state == HIGH) ? wdata[31:16] : wdata[15:0])
                               : 16'hzzzz;

  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;
  assign sram_ce_n = 1'b0;
  assign sram_oe_n = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller
//
// Directed bench for sram_controller. A small behavioural SRAM model sits
// on the bus: it drives the addressed half-word whenever sram_we_n is high
// (output enable is tied active) and stores the bus on rising edges while
// sram_we_n is low. Each feature task drives one scenario and compares
// against hand-computed values.
module tb_sram_controller;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;
  logic        sram_ce_n;
  logic        sram_oe_n;

  int checks;
  int errors;

  logic [15:0] mem [0:63] = '{default: 16'hA000};

  logic        obs_ready [0:5];
  logic [17:0] obs_addr  [0:5];
  logic [15:0] obs_dq    [0:5];
  logic        obs_we    [0:5];

  sram_controller dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_dq    (sram_dq),
    .sram_addr  (sram_addr),
    .sram_we_n  (sram_we_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sram_dq = sram_we_n ? mem[sram_addr[5:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic record(input int c);
    obs_ready[c] = ready;
    obs_addr[c]  = sram_addr;
    obs_dq[c]    = sram_dq;
    obs_we[c]    = sram_we_n;
  endtask

  // Presents a request at cycle 0 (controller in IDLE), records cycles
  // 0..5, drops the request during DONE, and leaves the bench one cycle
  // later in IDLE, ready for the next back-to-back request.
  task automatic run_access(input logic wr, input logic rd,
                            input logic [31:0] addr, input logic [31:0] data);
    wr_en      = wr;
    rd_en      = rd;
    address    = addr;
    write_data = data;
    #1;
    record(0);
    for (int c = 1; c <= 5; c++) begin
      step();
      record(c);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    address = '0;
    write_data = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 1", ready);
    end
    checks++;
    if (sram_we_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_we_n: got %b expected 1", sram_we_n);
    end
    checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_read_data: got %h expected 00000000", read_data);
    end
    checks++;
    if (sram_addr !== 18'h0) begin
      errors++;
      $display("[TB] FAIL reset_sram_addr: got %h expected 0", sram_addr);
    end
    checks++;
    if (sram_dq !== 16'hA000) begin
      errors++;
      $display("[TB] FAIL reset_dq_released: got %h expected a000", sram_dq);
    end
    step();
  endtask

  task automatic test_write_single();
    logic [17:0] ea;
    logic [15:0] ed;
    run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
    for (int c = 0; c <= 5; c++) begin
      checks++;
      if (obs_ready[c] !== (c == 5)) begin
        errors++;
        $display("[TB] FAIL write_ready[%0d]: got %b expected %b", c, obs_ready[c], c == 5);
      end
      checks++;
      if (obs_we[c] !== !(c >= 1 && c <= 4)) begin
        errors++;
        $display("[TB] FAIL write_we_n[%0d]: got %b expected %b", c, obs_we[c], !(c >= 1 && c <= 4));
      end
      if (c >= 1 && c <= 4) begin
        ea = (c <= 2) ? 18'd0 : 18'd1;
        ed = (c <= 2) ? 16'hBEEF : 16'hDEAD;
        checks++;
        if (obs_addr[c] !== ea) begin
          errors++;
          $display("[TB] FAIL write_addr[%0d]: got %h expected %h", c, obs_addr[c], ea);
        end
        checks++;
        if (obs_dq[c] !== ed) begin
          errors++;
          $display("[TB] FAIL write_dq[%0d]: got %h expected %h", c, obs_dq[c], ed);
        end
      end
    end
    checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL write_keeps_read_data: got %h expected 00000000", read_data);
    end
    checks++;
    if ({mem[1], mem[0]} !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL write_sram_contents: got %h expected deadbeef", {mem[1], mem[0]});
    end
  endtask

  task automatic test_read_single();
    run_access(1'b0, 1'b1, 32'd1024, 32'h0);
    for (int c = 0; c <= 5; c++) begin
      checks++;
      if (obs_ready[c] !== (c == 5)) begin
        errors++;
        $display("[TB] FAIL read_ready[%0d]: got %b expected %b", c, obs_ready[c], c == 5);
      end
      checks++;
      if (obs_we[c] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL read_we_n[%0d]: got %b expected 1", c, obs_we[c]);
      end
    end
    checks++;
    if (read_data !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL read_data: got %h expected deadbeef", read_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] st_addr [0:1];
    logic [31:0] st_data [0:1];
    logic [17:0] lo_addr [0:1];
    int          ready_count;
    st_addr[0] = 32'd1028; st_data[0] = 32'h12345678; lo_addr[0] = 18'd2;
    st_addr[1] = 32'd1032; st_data[1] = 32'hCAFEF00D; lo_addr[1] = 18'd4;
    for (int k = 0; k < 2; k++) begin
      run_access(1'b1, 1'b0, st_addr[k], st_data[k]);
      ready_count = 0;
      for (int c = 0; c <= 5; c++) if (obs_ready[c] === 1'b1) ready_count++;
      checks++;
      if (ready_count != 1 || obs_ready[5] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_store%0d_ready_once: got %0d ready cycles (last=%b) expected 1 at cycle 5", k, ready_count, obs_ready[5]);
      end
      checks++;
      if (obs_addr[1] !== lo_addr[k] || obs_addr[3] !== lo_addr[k] + 18'd1) begin
        errors++;
        $display("[TB] FAIL b2b_store%0d_addr: got %h/%h expected %h/%h", k, obs_addr[1], obs_addr[3], lo_addr[k], lo_addr[k] + 18'd1);
      end
      checks++;
      if (obs_dq[2] !== st_data[k][15:0] || obs_dq[4] !== st_data[k][31:16]) begin
        errors++;
        $display("[TB] FAIL b2b_store%0d_dq: got %h/%h expected %h/%h", k, obs_dq[2], obs_dq[4], st_data[k][15:0], st_data[k][31:16]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      run_access(1'b0, 1'b1, st_addr[k], 32'h0);
      ready_count = 0;
      for (int c = 0; c <= 5; c++) if (obs_ready[c] === 1'b1) ready_count++;
      checks++;
      if (ready_count != 1 || obs_ready[5] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_load%0d_ready_once: got %0d ready cycles (last=%b) expected 1 at cycle 5", k, ready_count, obs_ready[5]);
      end
      checks++;
      if (obs_addr[2] !== lo_addr[k] || obs_addr[4] !== lo_addr[k] + 18'd1) begin
        errors++;
        $display("[TB] FAIL b2b_load%0d_addr: got %h/%h expected %h/%h", k, obs_addr[2], obs_addr[4], lo_addr[k], lo_addr[k] + 18'd1);
      end
      checks++;
      if (read_data !== st_data[k]) begin
        errors++;
        $display("[TB] FAIL b2b_load%0d_data: got %h expected %h", k, read_data, st_data[k]);
      end
    end
  endtask

  task automatic test_write_priority();
    run_access(1'b1, 1'b1, 32'd1036, 32'h0000FFFF);
    checks++;
    if (obs_we[1] !== 1'b0 || obs_we[4] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_we_n: got %b/%b expected 0/0", obs_we[1], obs_we[4]);
    end
    checks++;
    if (obs_addr[1] !== 18'd6 || obs_addr[3] !== 18'd7) begin
      errors++;
      $display("[TB] FAIL prio_addr: got %h/%h expected 6/7", obs_addr[1], obs_addr[3]);
    end
    checks++;
    if (mem[6] !== 16'hFFFF || mem[7] !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL prio_sram_contents: got %h/%h expected ffff/0000", mem[6], mem[7]);
    end
    checks++;
    if (read_data !== 32'hCAFEF00D) begin
      errors++;
      $display("[TB] FAIL prio_read_data_kept: got %h expected cafef00d", read_data);
    end
  endtask

  task automatic test_reset_mid_access();
    wr_en      = 1'b1;
    rd_en      = 1'b0;
    address    = 32'd1040;
    write_data = 32'h55AA33CC;
    step();
    step();
    step();
    checks++;
    if (sram_we_n !== 1'b0 || sram_addr !== 18'd9 || sram_dq !== 16'h55AA) begin
      errors++;
      $display("[TB] FAIL midrst_in_high: got we_n=%b addr=%h dq=%h expected 0/9/55aa", sram_we_n, sram_addr, sram_dq);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (sram_we_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_we_n: got %b expected 1", sram_we_n);
    end
    checks++;
    if (sram_dq !== 16'hBEEF) begin
      errors++;
      $display("[TB] FAIL midrst_dq_released: got %h expected beef", sram_dq);
    end
    checks++;
    if (read_data !== 32'h0 || sram_addr !== 18'h0) begin
      errors++;
      $display("[TB] FAIL midrst_regs: got read_data=%h addr=%h expected 0/0", read_data, sram_addr);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_ready_with_req: got %b expected 0", ready);
    end
    wr_en = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_ready_no_req: got %b expected 1", ready);
    end
    rst = 1'b0;
    step();
    run_access(1'b0, 1'b1, 32'd1024, 32'h0);
    checks++;
    if (obs_ready[4] !== 1'b0 || obs_ready[5] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_fresh_latency: got ready c4=%b c5=%b expected 0/1", obs_ready[4], obs_ready[5]);
    end
    checks++;
    if (read_data !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL midrst_fresh_data: got %h expected deadbeef", read_data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    $display("[TB] starting sram_controller bench");
    test_reset();
    test_write_single();
    test_read_single();
    test_back_to_back();
    test_write_priority();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
